// File: rtl/bet_ledger.sv
// Baccarat bankroll ledger: locks a bet, settles it from the win lights, and latches BROKE at zero.
// Single-cycle registered updates with no backpressure; BET_LEDGER_TIE_BET_EN enables tie bets (side 11).
module bet_ledger (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic [9:0] SW,
  input  logic       bet_open,
  input  logic       round_done,
  input  logic       player_win,
  input  logic       dealer_win,
  output logic [7:0] balance,
  output logic [7:0] bet_amount,
  output logic [1:0] bet_side,
  output logic       bet_locked,
  output logic       payout_valid,
  output logic [7:0] last_payout,
  output logic       broke
);

  typedef enum logic [1:0] {BETTING, LOCKED, SETTLE, BROKE} state_t;

  state_t      state, state_n;
  logic [7:0]  balance_n, bet_amount_n, last_payout_n;
  logic [1:0]  bet_side_n;
  logic [1:0]  side_in;
  logic [7:0]  req_amount, debit;
  logic [11:0] bet12, ret, sum;

  always_comb begin
`ifdef BET_LEDGER_TIE_BET_EN
    side_in = SW[9:8];
`else
    side_in = (SW[9:8] == 2'b11) ? 2'b00 : SW[9:8];
`endif
    if (side_in == 2'b00)
      req_amount = 8'd0;
    else
      req_amount = (SW[7:0] < balance) ? SW[7:0] : balance;
    // A bet left over from the previous round may exceed what is left after settlement.
    debit = (bet_amount > balance) ? balance : bet_amount;
  end

  always_comb begin
    bet12 = {4'd0, bet_amount};
    ret   = 12'd0;
    unique case ({player_win, dealer_win})
      2'b00: ret = bet12;
      2'b10: if (bet_side == 2'b01) ret = bet12 << 1;
      2'b01: if (bet_side == 2'b10) ret = bet12 << 1;
      2'b11: begin
        if (bet_side == 2'b01 || bet_side == 2'b10) ret = bet12;
`ifdef BET_LEDGER_TIE_BET_EN
        else if (bet_side == 2'b11) ret = bet12 * 12'd9;
`endif
      end
    endcase
    sum = {4'd0, balance} + ret;
  end

  always_comb begin
    state_n       = state;
    balance_n     = balance;
    bet_amount_n  = bet_amount;
    bet_side_n    = bet_side;
    last_payout_n = last_payout;
    unique case (state)
      BETTING: begin
        if (bet_open) begin
          bet_side_n   = side_in;
          bet_amount_n = req_amount;
        end else begin
          state_n      = LOCKED;
          bet_amount_n = debit;
          balance_n    = balance - debit;
        end
      end
      LOCKED: begin
        if (round_done) begin
          state_n       = SETTLE;
          balance_n     = (sum > 12'd255) ? 8'd255 : sum[7:0];
          last_payout_n = (ret > 12'd255) ? 8'd255 : ret[7:0];
        end
      end
      SETTLE:  state_n = (balance == 8'd0) ? BROKE : BETTING;
      BROKE:   state_n = BROKE;
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state       <= BETTING;
      balance     <= 8'd100;
      bet_amount  <= 8'd0;
      bet_side    <= 2'b00;
      last_payout <= 8'd0;
    end else begin
      state       <= state_n;
      balance     <= balance_n;
      bet_amount  <= bet_amount_n;
      bet_side    <= bet_side_n;
      last_payout <= last_payout_n;
    end
  end

  assign bet_locked   = (state == LOCKED);
  assign payout_valid = (state == SETTLE);
  assign broke        = (state == BROKE);

endmodule

// File: tb/tb_bet_ledger.sv
// Directed self-checking bench for bet_ledger; expectations follow the BET_LEDGER_TIE_BET_EN setting.
module tb_bet_ledger;
  logic       slow_clock = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] SW = 10'd0;
  logic       bet_open = 1'b1;
  logic       round_done = 1'b0;
  logic       player_win = 1'b0;
  logic       dealer_win = 1'b0;
  logic [7:0] balance, bet_amount, last_payout;
  logic [1:0] bet_side;
  logic       bet_locked, payout_valid, broke;

  int checks = 0;
  int errors = 0;

  bet_ledger dut (
    .slow_clock(slow_clock), .reset(reset), .SW(SW), .bet_open(bet_open),
    .round_done(round_done), .player_win(player_win), .dealer_win(dealer_win),
    .balance(balance), .bet_amount(bet_amount), .bet_side(bet_side),
    .bet_locked(bet_locked), .payout_valid(payout_valid), .last_payout(last_payout),
    .broke(broke)
  );

  always #5 slow_clock = ~slow_clock;

  task automatic step();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; bet_open = 1'b1; SW = 10'd0;
    round_done = 1'b0; player_win = 1'b0; dealer_win = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (balance !== 8'd100) begin errors++; $display("FAIL reset_balance got %0d want 100", balance); end
    checks++; if (bet_amount !== 8'd0) begin errors++; $display("FAIL reset_bet_amount got %0d want 0", bet_amount); end
    checks++; if (bet_side !== 2'b00) begin errors++; $display("FAIL reset_bet_side got %b want 00", bet_side); end
    checks++; if ({bet_locked, payout_valid, broke} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {bet_locked, payout_valid, broke}); end
    checks++; if (last_payout !== 8'd0) begin errors++; $display("FAIL reset_last_payout got %0d want 0", last_payout); end
  endtask

  task automatic test_player_win();
    do_reset();
    SW = 10'b01_00010100; step();
    checks++; if (bet_amount !== 8'd20 || bet_side !== 2'b01) begin errors++; $display("FAIL pw_register got %0d/%b want 20/01", bet_amount, bet_side); end
    bet_open = 1'b0; SW = 10'b10_11111111; step();
    checks++; if (balance !== 8'd80 || bet_locked !== 1'b1) begin errors++; $display("FAIL pw_lock got %0d/%b want 80/1", balance, bet_locked); end
    bet_open = 1'b1; step();
    checks++; if (bet_amount !== 8'd20 || bet_side !== 2'b01 || balance !== 8'd80) begin errors++; $display("FAIL pw_locked_hold got %0d/%b/%0d want 20/01/80", bet_amount, bet_side, balance); end
    round_done = 1'b1; player_win = 1'b1; step();
    round_done = 1'b0; player_win = 1'b0;
    checks++; if (balance !== 8'd120 || last_payout !== 8'd40) begin errors++; $display("FAIL pw_settle got %0d/%0d want 120/40", balance, last_payout); end
    checks++; if (payout_valid !== 1'b1 || bet_locked !== 1'b0) begin errors++; $display("FAIL pw_settle_flags got %b/%b want 1/0", payout_valid, bet_locked); end
    step();
    checks++; if (payout_valid !== 1'b0 || broke !== 1'b0) begin errors++; $display("FAIL pw_after_settle got %b/%b want 0/0", payout_valid, broke); end
  endtask

  task automatic test_loss_push_back_to_back();
    do_reset();
    SW = 10'b01_00011110; step();
    bet_open = 1'b0; step();
    bet_open = 1'b1; round_done = 1'b1; dealer_win = 1'b1; step();
    round_done = 1'b0; dealer_win = 1'b0;
    checks++; if (balance !== 8'd70 || last_payout !== 8'd0) begin errors++; $display("FAIL loss got %0d/%0d want 70/0", balance, last_payout); end
    SW = 10'b10_00101000; step(); step();
    checks++; if (bet_amount !== 8'd40 || bet_side !== 2'b10) begin errors++; $display("FAIL b2b_register got %0d/%b want 40/10", bet_amount, bet_side); end
    bet_open = 1'b0; step();
    bet_open = 1'b1; round_done = 1'b1; player_win = 1'b1; dealer_win = 1'b1; step();
    round_done = 1'b0; player_win = 1'b0; dealer_win = 1'b0;
    checks++; if (balance !== 8'd70 || last_payout !== 8'd40) begin errors++; $display("FAIL push got %0d/%0d want 70/40", balance, last_payout); end
    step();
    round_done = 1'b1; player_win = 1'b1; step();
    round_done = 1'b0; player_win = 1'b0;
    checks++; if (balance !== 8'd70 || payout_valid !== 1'b0 || last_payout !== 8'd40) begin errors++; $display("FAIL stray_round_done got %0d/%b/%0d want 70/0/40", balance, payout_valid, last_payout); end
  endtask

  task automatic test_broke();
    do_reset();
    SW = 10'b10_11111111; step();
    checks++; if (bet_amount !== 8'd100) begin errors++; $display("FAIL broke_clamp got %0d want 100", bet_amount); end
    bet_open = 1'b0; step();
    checks++; if (balance !== 8'd0) begin errors++; $display("FAIL broke_lock got %0d want 0", balance); end
    round_done = 1'b1; player_win = 1'b1; step();
    round_done = 1'b0;
    checks++; if (balance !== 8'd0 || last_payout !== 8'd0 || payout_valid !== 1'b1) begin errors++; $display("FAIL broke_settle got %0d/%0d/%b want 0/0/1", balance, last_payout, payout_valid); end
    step();
    checks++; if (broke !== 1'b1) begin errors++; $display("FAIL broke_flag got %b want 1", broke); end
    for (int i = 0; i < 2; i++) begin
      bet_open = 1'b1; SW = 10'b01_00000101; round_done = 1'b1; dealer_win = 1'b0; step();
      bet_open = 1'b0; round_done = 1'b0; step();
    end
    checks++; if (broke !== 1'b1 || balance !== 8'd0 || payout_valid !== 1'b0 || bet_amount !== 8'd100 || bet_side !== 2'b10) begin
      errors++; $display("FAIL broke_hold got %b/%0d/%b/%0d/%b want 1/0/0/100/10", broke, balance, payout_valid, bet_amount, bet_side);
    end
    player_win = 1'b0;
  endtask

  task automatic test_tie();
    do_reset();
    SW = 10'b11_00010100; step();
`ifdef BET_LEDGER_TIE_BET_EN
    checks++; if (bet_amount !== 8'd20 || bet_side !== 2'b11) begin errors++; $display("FAIL tie_register got %0d/%b want 20/11", bet_amount, bet_side); end
`else
    checks++; if (bet_amount !== 8'd0 || bet_side !== 2'b00) begin errors++; $display("FAIL tie_register got %0d/%b want 0/00", bet_amount, bet_side); end
`endif
    bet_open = 1'b0; step();
    bet_open = 1'b1; round_done = 1'b1; player_win = 1'b1; dealer_win = 1'b1; step();
    round_done = 1'b0; player_win = 1'b0; dealer_win = 1'b0;
`ifdef BET_LEDGER_TIE_BET_EN
    checks++; if (balance !== 8'd255 || last_payout !== 8'd180) begin errors++; $display("FAIL tie_settle got %0d/%0d want 255/180", balance, last_payout); end
`else
    checks++; if (balance !== 8'd100 || last_payout !== 8'd0) begin errors++; $display("FAIL tie_settle got %0d/%0d want 100/0", balance, last_payout); end
`endif
    step();
  endtask

  task automatic test_void();
    do_reset();
    SW = 10'b01_00001010; step();
    bet_open = 1'b0; step();
    checks++; if (balance !== 8'd90) begin errors++; $display("FAIL void_lock got %0d want 90", balance); end
    bet_open = 1'b1; round_done = 1'b1; step();
    round_done = 1'b0;
    checks++; if (balance !== 8'd100 || last_payout !== 8'd10) begin errors++; $display("FAIL void_settle got %0d/%0d want 100/10", balance, last_payout); end
    step();
  endtask

  task automatic test_reset_locked();
    do_reset();
    SW = 10'b01_00110010; step();
    bet_open = 1'b0; step();
    checks++; if (balance !== 8'd50 || bet_locked !== 1'b1) begin errors++; $display("FAIL rl_lock got %0d/%b want 50/1", balance, bet_locked); end
    reset = 1'b1; step();
    reset = 1'b0;
    checks++; if (balance !== 8'd100 || bet_locked !== 1'b0 || bet_amount !== 8'd0) begin errors++; $display("FAIL rl_reset got %0d/%b/%0d want 100/0/0", balance, bet_locked, bet_amount); end
    bet_open = 1'b1; SW = 10'b10_00000111; step();
    checks++; if (bet_amount !== 8'd7 || bet_side !== 2'b10) begin errors++; $display("FAIL rl_betting got %0d/%b want 7/10", bet_amount, bet_side); end
  endtask

  task automatic test_reset_round_done();
    do_reset();
    SW = 10'b01_00010100; step();
    bet_open = 1'b0; step();
    reset = 1'b1; bet_open = 1'b1; round_done = 1'b1; player_win = 1'b1; step();
    reset = 1'b0; round_done = 1'b0; player_win = 1'b0;
    checks++; if (balance !== 8'd100 || payout_valid !== 1'b0 || last_payout !== 8'd0 || bet_locked !== 1'b0) begin
      errors++; $display("FAIL rrd got %0d/%b/%0d/%b want 100/0/0/0", balance, payout_valid, last_payout, bet_locked);
    end
  endtask

  initial begin
    test_reset();
    test_player_win();
    test_loss_push_back_to_back();
    test_broke();
    test_tie();
    test_void();
    test_reset_locked();
    test_reset_round_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bet_ledger.md
BET_LEDGER -- requirements
Module: bet_ledger

Interface
REQ-001 SHALL have port: slow_clock  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on slow_clock rising edge.
REQ-003 SHALL have port: SW  input  10  SW[7:0] requested bet amount (unsigned); SW[9:8] bet side (00 none, 01 player, 10 banker, 11 tie).
REQ-004 SHALL have port: bet_open  input  1  high while the round controller accepts bets.
REQ-005 SHALL have port: round_done  input  1  one-cycle pulse after the final hand is scored.
REQ-006 SHALL have port: player_win  input  1  player win light, valid when round_done is high.
REQ-007 SHALL have port: dealer_win  input  1  dealer win light, valid when round_done is high; both lights high means tie.
REQ-008 SHALL have port: balance  output  8  current bankroll (unsigned).
REQ-009 SHALL have port: bet_amount  output  8  registered bet for the current round.
REQ-010 SHALL have port: bet_side  output  2  registered bet side, same encoding as SW[9:8].
REQ-011 SHALL have port: bet_locked  output  1  high from lock until settlement.
REQ-012 SHALL have port: payout_valid  output  1  one-cycle pulse in SETTLE.
REQ-013 SHALL have port: last_payout  output  8  saturated amount credited at the last settlement.
REQ-014 SHALL have port: broke  output  1  high in BROKE state.

Function
REQ-015 SHALL implement states BETTING, LOCKED, SETTLE, BROKE.
REQ-016 In BETTING with bet_open=1, SHALL register bet_side<=SW[9:8] and bet_amount<=min(SW[7:0], balance) every cycle.
REQ-017 SHALL force bet_amount to 0 when the registered side is 00.
REQ-018 In BETTING with bet_open=0, SHALL go to LOCKED, subtract bet_amount from balance in the same cycle, and assert bet_locked from the next cycle.
REQ-019 In LOCKED, SHALL ignore SW and bet_open, and SHALL move to SETTLE on round_done=1.
REQ-020 On round_done, SHALL compute the return from the registered outcome: player-only win, dealer-only win, tie (both high), or void (both low).
REQ-021 Return SHALL be 2*bet for a player bet on a player win or a banker bet on a dealer win.
REQ-022 Return SHALL be 9*bet for a tie bet on a tie.
REQ-023 Return SHALL be 1*bet (push) for a player or banker bet on a tie.
REQ-024 Return SHALL be 1*bet (refund) for any bet on a void round.
REQ-025 Return SHALL be 0 for every other combination.
REQ-026 SHALL compute the return in at least 12 bits and saturate balance+return at 255.
REQ-027 SHALL set last_payout to the credited amount, saturated to 255.
REQ-028 In SETTLE (exactly one cycle), SHALL credit balance, pulse payout_valid, and clear bet_locked.
REQ-029 From SETTLE, SHALL go to BROKE if the new balance is 0, else to BETTING.
REQ-030 In BROKE, SHALL hold all outputs with broke=1; only reset leaves BROKE.
REQ-031 SHALL ignore round_done outside LOCKED.
REQ-032 SHALL give reset priority over every simultaneous event.

Reset
REQ-033 On reset, SHALL enter BETTING and set outputs: balance=100, bet_amount=0, bet_side=00, bet_locked=0, payout_valid=0, last_payout=0, broke=0.
REQ-034 Reset asserted mid-round SHALL discard the locked bet without refund and restore balance to 100.

Configuration
REQ-035 SHALL support macro BET_LEDGER_TIE_BET_EN.
REQ-036 When BET_LEDGER_TIE_BET_EN is defined, side 11 SHALL be accepted with 9*bet tie return.
REQ-037 When BET_LEDGER_TIE_BET_EN is undefined, side 11 SHALL be registered as 00 with bet_amount=0.

Verification
REQ-038 Reset, SW=01_00010100, bet_open 1->0, round_done with player_win=1 -> balance 80 at lock, 120 after SETTLE, last_payout=40.
REQ-039 Balance 100, SW=10_11111111 (clamped to 100), banker bet, player wins -> balance 0, then broke=1 and state held across further round_done pulses.
REQ-040 Balance 100, tie bet 20 with macro defined, both lights high -> return 180, balance 255 (saturated), last_payout=180; without macro -> bet_amount=0, balance stays 100.
REQ-041 Balance 100, player bet 10, round_done with both lights low -> balance 90 then 100, last_payout=10.
REQ-042 Reset asserted in LOCKED holding a bet of 50 -> next cycle balance=100, bet_locked=0, state BETTING.
REQ-043 Reset and round_done asserted in the same cycle -> reset values, payout_valid=0.
